// File: rtl/reg_file_dump_pkg.sv
// Shared core constants and dump-engine state encodings.
// Used by the register file, the dump engine and its stream interface.
package reg_file_dump_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef enum logic [1:0] {
      DUMP_IDLE  = 2'd0,
      DUMP_RUN   = 2'd1,
      DUMP_DRAIN = 2'd2
   } dump_state_e;

   // Number of words a dump of [first, last] produces.
   function automatic int f_range_len(
      input int first,
      input int last
   );
      return last - first + 1;
   endfunction

endpackage

// File: rtl/reg_file_dump_if.sv
// Valid/ready word stream carrying {addr, data} register dump words.
// Ports: valid, ready, data[DATA_W], addr[ADDR_W]; master drives the word.
interface reg_file_dump_if
   import reg_file_dump_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = XLEN
);

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] addr;

   modport master (
      output valid,
      output data,
      output addr,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  addr,
      output ready
   );

endinterface

// File: rtl/reg_file_dump.sv
// Register-file dump engine: walks [FIRST_ADDR, LAST_ADDR] through one
// read port and streams each {addr, data} word over o_stream.
// Ports: i_clk, i_rst (async, active high), i_start, o_rd_addr/i_rd_data
// (register-file read port), o_stream (master: valid/ready/data/addr),
// o_busy (not IDLE), o_done (one-cycle pulse after the last word).
module reg_file_dump
   import reg_file_dump_pkg::*;
#(
   parameter int ADDR_W     = REG_ADDR_W,
   parameter int DATA_W     = XLEN,
   parameter int FIRST_ADDR = 0,
   parameter int LAST_ADDR  = 31
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   reg_file_dump_if.master   o_stream,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] LP_FIRST =
      ADDR_W'(FIRST_ADDR);
   localparam logic [ADDR_W-1:0] LP_LAST  =
      ADDR_W'(LAST_ADDR);

   dump_state_e       r_state;
   dump_state_e       w_state_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_data_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              r_done;
   logic              w_done_nxt;

   logic              w_is_idle;
   logic              w_is_run;
   logic              w_is_drain;
   logic              w_load;
   logic              w_accept;
   logic              w_last;

   assign w_is_idle  = (r_state == DUMP_IDLE);
   assign w_is_run   = (r_state == DUMP_RUN);
   assign w_is_drain = (r_state == DUMP_DRAIN);

   // The output register may refill whenever it is empty or
   // its current word is leaving on this edge.
   assign w_accept = r_valid && o_stream.ready;
   assign w_load   = w_is_run && (!r_valid || o_stream.ready);
   assign w_last   = (r_ptr == LP_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= DUMP_IDLE;
         r_ptr   <= LP_FIRST;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_addr  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
         r_addr  <= w_addr_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      w_addr_nxt  = r_addr;
      w_done_nxt  = 1'b0;

      unique case (1'b1)
         w_is_idle: begin
            w_valid_nxt = 1'b0;
            if (i_start) begin
               w_ptr_nxt   = LP_FIRST;
               w_state_nxt = DUMP_RUN;
            end
         end
         w_is_run: begin
            if (w_load) begin
               w_data_nxt  = i_rd_data;
               w_addr_nxt  = r_ptr;
               w_valid_nxt = 1'b1;
               // Never step past the last address, so
               // the pointer cannot wrap.
               if (w_last) begin
                  w_state_nxt = DUMP_DRAIN;
               end else begin
                  w_ptr_nxt = r_ptr + ADDR_W'(1);
               end
            end
         end
         w_is_drain: begin
            if (w_accept) begin
               w_valid_nxt = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = DUMP_IDLE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = DUMP_IDLE;
         end
      endcase
   end

   assign o_rd_addr      = r_ptr;
   assign o_stream.valid = r_valid;
   assign o_stream.data  = r_data;
   assign o_stream.addr  = r_addr;
   assign o_busy         = !w_is_idle;
   assign o_done         = r_done;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: full range DUT and a one-word DUT.
// Drives on negedge, samples on negedge after each active edge.
module tb_reg_file_dump;

   logic        i_clk;
   logic        i_rst;

   logic        start0;
   logic [4:0]  rd_addr0;
   logic [31:0] rd_data0;
   logic        busy0;
   logic        done0;

   logic        start1;
   logic [4:0]  rd_addr1;
   logic [31:0] rd_data1;
   logic        busy1;
   logic        done1;

   logic [31:0] regs [32];

   int checks;
   int failures;

   reg_file_dump_if #(.ADDR_W(5), .DATA_W(32)) u_if0 ();
   reg_file_dump_if #(.ADDR_W(5), .DATA_W(32)) u_if1 ();

   assign rd_data0 = regs[rd_addr0];
   assign rd_data1 = regs[rd_addr1];

   reg_file_dump #(
      .ADDR_W(5), .DATA_W(32),
      .FIRST_ADDR(0), .LAST_ADDR(31)
   ) u_dut0 (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_start(start0),
      .o_rd_addr(rd_addr0),
      .i_rd_data(rd_data0),
      .o_stream(u_if0),
      .o_busy(busy0),
      .o_done(done0)
   );

   reg_file_dump #(
      .ADDR_W(5), .DATA_W(32),
      .FIRST_ADDR(7), .LAST_ADDR(7)
   ) u_dut1 (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_start(start1),
      .o_rd_addr(rd_addr1),
      .i_rd_data(rd_data1),
      .o_stream(u_if1),
      .o_busy(busy1),
      .o_done(done1)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      int          stall_addr;
      int          stall_len;
      logic [31:0] stall_data;
      int          restart_addr;
      int          exp_words;
      int          exp_done;
   } dump_vec_t;

   dump_vec_t vecs [3];

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int a);
      logic [31:0] m;
      m = 32'h0101_0101;
      if (a == 7) return 32'hfefe_efef;
      return m * 32'(a);
   endfunction

   task automatic run_dump(input dump_vec_t v);
      int c;
      int nw;
      int ndone;
      int done_c;
      int stall_left;
      bit restarted;
      bit stop;
      nw = 0;
      ndone = 0;
      done_c = -1;
      stall_left = v.stall_len;
      restarted = 0;
      stop = 0;
      @(negedge i_clk);
      start0 = 1'b1;
      u_if0.ready = 1'b1;
      @(posedge i_clk);
      c = 0;
      while (!stop && c < 200) begin
         @(negedge i_clk);
         start0 = 1'b0;
         if (c == 0) chk("busy_after_start", 32'(busy0), 1);
         if (done0) begin
            ndone++;
            if (done_c < 0) done_c = c;
         end
         u_if0.ready = 1'b1;
         if (u_if0.valid && int'(u_if0.addr) == v.stall_addr
             && stall_left > 0) begin
            u_if0.ready = 1'b0;
            stall_left--;
            chk("stall_hold_data", u_if0.data, v.stall_data);
         end
         if (u_if0.valid && int'(u_if0.addr) == v.restart_addr
             && !restarted) begin
            start0 = 1'b1;
            restarted = 1;
         end
         if (u_if0.valid && u_if0.ready) begin
            chk("word_addr", 32'(u_if0.addr), 32'(nw));
            chk("word_data", u_if0.data, exp_data(nw));
            nw++;
         end
         if (done_c >= 0 && c >= done_c + 2) stop = 1;
         @(posedge i_clk);
         c++;
      end
      @(negedge i_clk);
      start0 = 1'b0;
      chk("word_count", 32'(nw), 32'(v.exp_words));
      chk("done_cycle", 32'(done_c), 32'(v.exp_done));
      chk("done_pulses", 32'(ndone), 1);
      chk("busy_end", 32'(busy0), 0);
   endtask

   initial begin
      checks = 0;
      failures = 0;

      vecs[0] = '{99, 0, 32'h0, 99, 32, 33};
      vecs[1] = '{4, 3, 32'h0404_0404, 99, 32, 36};
      vecs[2] = '{99, 0, 32'h0, 10, 32, 33};

      for (int i = 0; i < 32; i++) begin
         regs[i] = 32'h0101_0101 * 32'(i);
      end
      regs[7] = 32'hfefe_efef;

      i_rst = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      u_if0.ready = 1'b0;
      u_if1.ready = 1'b0;

      // Reset asserted before any clock edge.
      #2 i_rst = 1'b1;
      #1;
      chk("rst_valid", 32'(u_if0.valid), 0);
      chk("rst_data", u_if0.data, 0);
      chk("rst_addr", 32'(u_if0.addr), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_rd_addr", 32'(rd_addr0), 0);
      chk("rst_rd_addr1", 32'(rd_addr1), 7);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         run_dump(vecs[i]);
      end

      // Reset in the middle of a dump.
      @(negedge i_clk);
      start0 = 1'b1;
      u_if0.ready = 1'b1;
      @(negedge i_clk);
      start0 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (u_if0.valid && u_if0.addr == 5'd10) break;
         @(negedge i_clk);
      end
      chk("mid_reached", 32'(u_if0.addr), 10);
      #2 i_rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(u_if0.valid), 0);
      chk("mid_rst_busy", 32'(busy0), 0);
      chk("mid_rst_data", u_if0.data, 0);
      chk("mid_rst_addr", 32'(u_if0.addr), 0);
      chk("mid_rst_rd_addr", 32'(rd_addr0), 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("no_done_after_rst", 32'(done0), 0);
      end
      run_dump(vecs[0]);

      // One-word range, plus start taken in the done cycle.
      @(negedge i_clk);
      start1 = 1'b1;
      u_if1.ready = 1'b1;
      @(negedge i_clk);
      start1 = 1'b0;
      chk("sw_busy", 32'(busy1), 1);
      chk("sw_valid_early", 32'(u_if1.valid), 0);
      chk("sw_rd_addr", 32'(rd_addr1), 7);
      @(negedge i_clk);
      chk("sw_valid", 32'(u_if1.valid), 1);
      chk("sw_addr", 32'(u_if1.addr), 7);
      chk("sw_data", u_if1.data, 32'hfefe_efef);
      chk("sw_done_early", 32'(done1), 0);
      @(negedge i_clk);
      chk("sw_done", 32'(done1), 1);
      chk("sw_valid_off", 32'(u_if1.valid), 0);
      chk("sw_busy_off", 32'(busy1), 0);
      start1 = 1'b1;
      @(negedge i_clk);
      start1 = 1'b0;
      chk("sw_restart_busy", 32'(busy1), 1);
      chk("sw_done_once", 32'(done1), 0);
      repeat (4) @(negedge i_clk);
      chk("sw_idle_end", 32'(busy1), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
